kernel_dispatch_queue: RTL and testbench
========================================

Name: kernel_dispatch_queue

Overview:
Parametrised successor to the single-launch block dispatcher in the GPU top level. It accepts a queue of kernel launches, each with its own thread count and kernel ID. Each kernel is split into blocks of THREADS_PER_BLOCK threads, which are issued to any number of logical cores with per-core reset/start/done handshakes. A completion pulse is emitted per kernel. It sits between the host launch interface and the core array, replacing the dcr plus dispatch pair.

Parameters:
NUM_LOGICAL_CORES, 4, number of logical cores driven (>=1)
THREADS_PER_BLOCK, 4, threads per block, power of two (>=1)
THREAD_COUNT_BITS, 8, width of thread count and block ID
QUEUE_DEPTH, 4, launch queue entries, power of two (>=2)
KERNEL_ID_BITS, 2, width of kernel ID tag

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
launch_valid  in  1  launch request present
launch_ready  out  1  queue can accept a launch
launch_thread_count  in  THREAD_COUNT_BITS  total threads for kernel
launch_kernel_id  in  KERNEL_ID_BITS  tag returned on completion
core_reset  out  NUM_LOGICAL_CORES  per-core one-cycle reset pulse
core_start  out  NUM_LOGICAL_CORES  per-core start, held until done
core_done  in  NUM_LOGICAL_CORES  per-core block-complete
core_block_id  out  NUM_LOGICAL_CORES*THREAD_COUNT_BITS  flattened, core k at [k*TCB +: TCB]
core_thread_count  out  NUM_LOGICAL_CORES*($clog2(THREADS_PER_BLOCK)+1)  flattened active threads per core
core_kernel_id  out  NUM_LOGICAL_CORES*KERNEL_ID_BITS  flattened kernel tag per core
kernel_done_valid  out  1  one-cycle completion pulse
kernel_done_id  out  KERNEL_ID_BITS  tag of completed kernel
busy  out  1  queue non-empty or kernel in flight
queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied queue entries

Behaviour:
- Reset (reset=0, async): all outputs 0, including launch_ready. Queue flushed, FSM to IDLE, all cores FREE. Reset mid-kernel abandons the kernel and emits no done pulse. After release, launch_ready=1.
- Queue: FIFO. Push on the edge where launch_valid && launch_ready. launch_ready = !full. A push and pop in the same cycle leave the count unchanged. A push while full is impossible, since ready=0.
- Dispatch FSM states: IDLE, LOAD, RUN.
  - IDLE: if the queue is non-empty, go to LOAD, popping the head into the current-kernel registers.
  - LOAD: total_blocks = ceil(tc / TPB), computed at THREAD_COUNT_BITS+1 width with no overflow; reset dispatched/completed counters.
    - If total_blocks==0: pulse kernel_done_valid with the tag in the next cycle and return to IDLE.
    - Otherwise go to RUN.
  - RUN: at most one block issued per cycle, to the lowest-index FREE core, while dispatched < total_blocks.
    - Block ID = dispatched count.
    - Thread count = TPB, except the last block gets tc - (total_blocks-1)*TPB.
    - When completed == total_blocks: pulse kernel_done_valid/kernel_done_id for exactly one cycle, then go to IDLE.
- Kernels never overlap; the next kernel loads only after the previous done pulse.
- Per-core states: FREE, RST, BUSY.
  - Assignment: FREE -> RST with core_reset=1 for one cycle; block_id, thread_count and kernel_id are latched and held stable until the next assignment.
  - RST -> BUSY: core_start=1.
  - BUSY with core_done=1: core_start drops next cycle, completed increments, core goes to FREE. The core is reassignable in the cycle after it becomes FREE.
- core_done on a core not in BUSY is ignored. Several cores finishing in the same cycle all count, so the completed increment equals popcount.
- Latency: with an empty queue and idle FSM, launch accepted at edge E0 gives LOAD at E1, RUN at E2, and core 0 core_reset high after E3, core_start high after E4.
- busy = (queue_count!=0) || state!=IDLE.

Test Plan:
1. Reset release, push tc=8 id=1 with 4 cores, TPB=4 -> cores 0,1 reset on consecutive cycles; block_id 0,1; thread_count 4,4; cores 2,3 untouched. Raise core_done 0,1 -> one kernel_done_valid with id=1; busy falls.
2. tc=10, 2 cores -> blocks 0..2, last thread_count=2. Block 2 goes to the first core freed. kernel_done only after the third done.
3. Fill queue with 4 launches (ids 0..3) while stalled -> launch_ready=0 and queue_count=4; a 5th valid is not accepted. Done pulses arrive in order 0,1,2,3.
4. tc=0 id=2 -> no core_reset/start; kernel_done_valid with id=2 exactly one cycle after LOAD.
5. Two cores raise core_done in the same cycle for a 2-block kernel -> completion counted once per core; single done pulse next cycle.
6. Assert reset mid-RUN with 2 blocks outstanding -> all core_start/core_reset 0 immediately, queue_count=0, no done pulse. A new launch afterwards dispatches from block 0.

Source files
------------

// File: rtl/kernel_dispatch_queue.sv
// Kernel launch queue and block dispatcher: splits each queued kernel into
// THREADS_PER_BLOCK-sized blocks and hands them to free logical cores.

module kdq_core_slot #(
    parameter int TCB = 8,
    parameter int CW  = 3,
    parameter int KIB = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           assign_en,
    input  logic [TCB-1:0] blk_in,
    input  logic [CW-1:0]  thr_in,
    input  logic [KIB-1:0] kid_in,
    input  logic           core_done,
    output logic           is_free,
    output logic           done_hit,
    output logic           core_reset,
    output logic           core_start,
    output logic [TCB-1:0] block_id,
    output logic [CW-1:0]  thread_count,
    output logic [KIB-1:0] kernel_id
);
    typedef enum logic [1:0] {FREE, RST, BUSY} slot_state_t;

    slot_state_t state, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FREE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            FREE:    if (assign_en) state_d = RST;
            RST:     state_d = BUSY;
            BUSY:    if (core_done) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    // Block descriptor stays stable until the core is handed a new block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_id     <= '0;
            thread_count <= '0;
            kernel_id    <= '0;
        end else if (assign_en) begin
            block_id     <= blk_in;
            thread_count <= thr_in;
            kernel_id    <= kid_in;
        end
    end

    assign is_free    = (state == FREE);
    assign core_reset = (state == RST);
    assign core_start = (state == BUSY);
    assign done_hit   = core_done && (state == BUSY);
endmodule

module kernel_dispatch_queue #(
    parameter int NUM_LOGICAL_CORES = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int QUEUE_DEPTH       = 4,
    parameter int KERNEL_ID_BITS    = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        launch_valid,
    output logic                                        launch_ready,
    input  logic [THREAD_COUNT_BITS-1:0]                launch_thread_count,
    input  logic [KERNEL_ID_BITS-1:0]                   launch_kernel_id,
    output logic [NUM_LOGICAL_CORES-1:0]                core_reset,
    output logic [NUM_LOGICAL_CORES-1:0]                core_start,
    input  logic [NUM_LOGICAL_CORES-1:0]                core_done,
    output logic [NUM_LOGICAL_CORES*THREAD_COUNT_BITS-1:0] core_block_id,
    output logic [NUM_LOGICAL_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
    output logic [NUM_LOGICAL_CORES*KERNEL_ID_BITS-1:0] core_kernel_id,
    output logic                                        kernel_done_valid,
    output logic [KERNEL_ID_BITS-1:0]                   kernel_done_id,
    output logic                                        busy,
    output logic [$clog2(QUEUE_DEPTH):0]                queue_count
);
    localparam int NC      = NUM_LOGICAL_CORES;
    localparam int TCB     = THREAD_COUNT_BITS;
    localparam int KIB     = KERNEL_ID_BITS;
    localparam int TPB_LOG = $clog2(THREADS_PER_BLOCK);
    localparam int CW      = TPB_LOG + 1;
    localparam int PW      = $clog2(QUEUE_DEPTH);
    localparam int QCW     = PW + 1;
    localparam int BW      = TCB + 1;

    typedef struct packed {
        logic [TCB-1:0] tc;
        logic [KIB-1:0] id;
    } launch_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} disp_state_t;

    launch_t     queue_mem [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    launch_t     cur;
    disp_state_t state, state_d;
    logic [BW-1:0] total_blocks, dispatched, completed;
    logic [BW-1:0] total_calc, done_cnt;
    logic          push, pop, done_d, found;
    logic [NC-1:0] issue_vec, slot_free, done_hit;
    logic [CW-1:0] issue_thr;

    assign launch_ready = reset && (queue_count != QCW'(QUEUE_DEPTH));
    assign push         = launch_valid && launch_ready;
    assign busy         = (queue_count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) queue_mem[wr_ptr] <= '{tc: launch_thread_count, id: launch_kernel_id};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            queue_count <= queue_count + QCW'(push) - QCW'(pop);
        end
    end

    // Wide enough that ceil(max_tc / TPB) never overflows.
    assign total_calc = (BW'(cur.tc) + BW'(THREADS_PER_BLOCK - 1)) >> TPB_LOG;

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        done_d    = 1'b0;
        found     = 1'b0;
        issue_vec = '0;
        done_cnt  = '0;
        for (int k = 0; k < NC; k++) done_cnt = done_cnt + BW'(done_hit[k]);
        case (state)
            IDLE: if (queue_count != '0) begin
                pop     = 1'b1;
                state_d = LOAD;
            end
            LOAD: if (total_calc == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
            RUN: begin
                // The final completions retire the kernel on the same edge they are counted.
                if (completed + done_cnt == total_blocks) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (dispatched < total_blocks) begin
                    for (int k = 0; k < NC; k++) begin
                        if (slot_free[k] && !found) begin
                            issue_vec[k] = 1'b1;
                            found        = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_thr = (dispatched == total_blocks - 1'b1)
                     ? CW'(BW'(cur.tc) - ((total_blocks - 1'b1) << TPB_LOG))
                     : CW'(THREADS_PER_BLOCK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cur               <= '0;
            total_blocks      <= '0;
            dispatched        <= '0;
            completed         <= '0;
            kernel_done_valid <= 1'b0;
            kernel_done_id    <= '0;
        end else begin
            state             <= state_d;
            kernel_done_valid <= done_d;
            if (done_d) kernel_done_id <= cur.id;
            if (pop)    cur <= queue_mem[rd_ptr];
            if (state == LOAD) begin
                total_blocks <= total_calc;
                dispatched   <= '0;
                completed    <= '0;
            end else if (state == RUN) begin
                dispatched <= dispatched + BW'(found);
                completed  <= completed + done_cnt;
            end
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_slot
        kdq_core_slot #(.TCB(TCB), .CW(CW), .KIB(KIB)) u_slot (
            .clk          (clk),
            .reset        (reset),
            .assign_en    (issue_vec[g]),
            .blk_in       (dispatched[TCB-1:0]),
            .thr_in       (issue_thr),
            .kid_in       (cur.id),
            .core_done    (core_done[g]),
            .is_free      (slot_free[g]),
            .done_hit     (done_hit[g]),
            .core_reset   (core_reset[g]),
            .core_start   (core_start[g]),
            .block_id     (core_block_id[g*TCB +: TCB]),
            .thread_count (core_thread_count[g*CW +: CW]),
            .kernel_id    (core_kernel_id[g*KIB +: KIB])
        );
    end
endmodule

// File: tb/tb_kernel_dispatch_queue.sv
// Directed bench for kernel_dispatch_queue: a vector table of kernels plus
// hand-timed sequences for latency, stalls, simultaneous done and mid-run reset.

module tb_kernel_dispatch_queue;
    localparam int NC = 4, NC2 = 2, TCB = 8, KIB = 2, CW = 3, QCW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              lv1, lr1, kdv1, busy1, auto_done;
    logic [TCB-1:0]    ltc1;
    logic [KIB-1:0]    lid1, kdid1;
    logic [NC-1:0]     crst1, cst1, cdone1, man_done1;
    logic [NC*TCB-1:0] cbid1;
    logic [NC*CW-1:0]  ctc1;
    logic [NC*KIB-1:0] ckid1;
    logic [QCW-1:0]    qc1;

    logic               lv2, lr2, kdv2, busy2;
    logic [TCB-1:0]     ltc2;
    logic [KIB-1:0]     lid2, kdid2;
    logic [NC2-1:0]     crst2, cst2, man_done2;
    logic [NC2*TCB-1:0] cbid2;
    logic [NC2*CW-1:0]  ctc2;
    logic [NC2*KIB-1:0] ckid2;
    logic [QCW-1:0]     qc2;

    assign cdone1 = auto_done ? cst1 : man_done1;

    kernel_dispatch_queue #(.NUM_LOGICAL_CORES(NC)) u_dut (
        .clk(clk), .reset(reset), .launch_valid(lv1), .launch_ready(lr1),
        .launch_thread_count(ltc1), .launch_kernel_id(lid1),
        .core_reset(crst1), .core_start(cst1), .core_done(cdone1),
        .core_block_id(cbid1), .core_thread_count(ctc1), .core_kernel_id(ckid1),
        .kernel_done_valid(kdv1), .kernel_done_id(kdid1), .busy(busy1), .queue_count(qc1)
    );

    kernel_dispatch_queue #(.NUM_LOGICAL_CORES(NC2)) u_dut2 (
        .clk(clk), .reset(reset), .launch_valid(lv2), .launch_ready(lr2),
        .launch_thread_count(ltc2), .launch_kernel_id(lid2),
        .core_reset(crst2), .core_start(cst2), .core_done(man_done2),
        .core_block_id(cbid2), .core_thread_count(ctc2), .core_kernel_id(ckid2),
        .kernel_done_valid(kdv2), .kernel_done_id(kdid2), .busy(busy2), .queue_count(qc2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push1(input int tc, input int id);
        int n = 0;
        lv1 = 1'b1; ltc1 = tc[TCB-1:0]; lid1 = id[KIB-1:0];
        while (!lr1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        lv1 = 1'b0;
    endtask

    task automatic wait_start(input logic [NC-1:0] mask, input string name);
        int n = 0;
        while (cst1 !== mask && n < 50) begin @(negedge clk); n++; end
        chk(name, cst1, mask);
    endtask

    task automatic wait_done(input string name, input int id);
        int n = 0;
        while (!kdv1 && n < 100) begin @(negedge clk); n++; end
        chk(name, {kdv1, 30'd0, 1'b0} | kdid1, {1'b1, 31'd0} | id);
        @(negedge clk);
    endtask

    task automatic run_kernel(input int tc, input int id, input int blocks,
                              input int last, input int mask, input string tag);
        int nblk = 0, ndone = 0, id_err = 0, tc_err = 0, kid_err = 0;
        int last_tc = 0, got_id = -1, used = 0, cyc = 0;
        bit fin = 0;
        auto_done = 1'b1;
        push1(tc, id);
        while (!fin && cyc < 600) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < NC; k++) begin
                if (crst1[k]) begin
                    if (int'(cbid1[k*TCB +: TCB]) != nblk) id_err++;
                    if (int'(ckid1[k*KIB +: KIB]) != id) kid_err++;
                    last_tc = int'(ctc1[k*CW +: CW]);
                    if (nblk < blocks - 1 && last_tc != 4) tc_err++;
                    used |= (1 << k);
                    nblk++;
                end
            end
            if (kdv1) begin
                ndone++; got_id = int'(kdid1);
                if (!busy1) fin = 1;
            end
        end
        repeat (3) begin @(negedge clk); if (kdv1) ndone++; end
        chk({tag, " blocks"}, nblk, blocks);
        chk({tag, " block_id order"}, id_err, 0);
        chk({tag, " core kernel_id"}, kid_err, 0);
        chk({tag, " full thread counts"}, tc_err, 0);
        if (blocks > 0) chk({tag, " last thread count"}, last_tc, last);
        chk({tag, " cores used"}, used, mask);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " done id"}, got_id, id);
        chk({tag, " busy after"}, busy1, 0);
    endtask

    typedef struct {
        int tc; int id; int blocks; int last; int mask;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int exp_ids[5];
        int idx, cyc, spurious;

        vecs[0] = '{tc: 8,   id: 1, blocks: 2,  last: 4, mask: 3};
        vecs[1] = '{tc: 10,  id: 2, blocks: 3,  last: 2, mask: 7};
        vecs[2] = '{tc: 0,   id: 3, blocks: 0,  last: 0, mask: 0};
        vecs[3] = '{tc: 1,   id: 0, blocks: 1,  last: 1, mask: 1};
        vecs[4] = '{tc: 5,   id: 1, blocks: 2,  last: 1, mask: 3};
        vecs[5] = '{tc: 255, id: 2, blocks: 64, last: 3, mask: 7};
        vecs[6] = '{tc: 4,   id: 3, blocks: 1,  last: 4, mask: 1};

        lv1 = 0; ltc1 = '0; lid1 = '0; man_done1 = '0; auto_done = 0;
        lv2 = 0; ltc2 = '0; lid2 = '0; man_done2 = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst launch_ready", lr1, 0);
        chk("rst busy", busy1, 0);
        chk("rst queue_count", qc1, 0);
        chk("rst core_reset", crst1, 0);
        chk("rst core_start", cst1, 0);
        chk("rst done_valid", kdv1, 0);
        chk("rst block_id", cbid1, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post-rst launch_ready", lr1, 1);

        // launch-to-core latency
        push1(4, 1);
        @(negedge clk);
        chk("lat E1 busy", busy1, 1);
        chk("lat E1 queue_count", qc1, 0);
        @(negedge clk);
        chk("lat E2 core_reset", crst1, 0);
        @(negedge clk);
        chk("lat E3 core_reset", crst1, 4'b0001);
        chk("lat E3 core_start", cst1, 0);
        @(negedge clk);
        chk("lat E4 core_reset", crst1, 0);
        chk("lat E4 core_start", cst1, 4'b0001);
        chk("lat E4 block_id", cbid1[TCB-1:0], 0);
        chk("lat E4 thread_count", ctc1[CW-1:0], 4);
        auto_done = 1;
        wait_done("lat done", 1);

        // vector table
        for (int v = 0; v < 7; v++)
            run_kernel(vecs[v].tc, vecs[v].id, vecs[v].blocks, vecs[v].last,
                       vecs[v].mask, $sformatf("vec%0d", v));

        // zero-thread kernel: done exactly one cycle after LOAD
        auto_done = 0;
        push1(0, 2);
        @(negedge clk);
        chk("tc0 LOAD done_valid", kdv1, 0);
        @(negedge clk);
        chk("tc0 done_valid", kdv1, 1);
        chk("tc0 done_id", kdid1, 2);
        chk("tc0 no core activity", {crst1, cst1}, 0);
        @(negedge clk);
        chk("tc0 single pulse", kdv1, 0);
        chk("tc0 busy", busy1, 0);

        // two cores, tc=10: third block goes to the first freed core
        lv2 = 1; ltc2 = 8'd10; lid2 = 2'd3;
        @(posedge clk);
        @(negedge clk); lv2 = 0;
        repeat (3) @(negedge clk);
        chk("c2 core0 reset", crst2, 2'b01);
        chk("c2 core0 block_id", cbid2[TCB-1:0], 0);
        @(negedge clk);
        chk("c2 core1 reset", crst2, 2'b10);
        chk("c2 core1 block_id", cbid2[2*TCB-1:TCB], 1);
        chk("c2 core1 threads", ctc2[2*CW-1:CW], 4);
        @(negedge clk);
        chk("c2 both started", cst2, 2'b11);
        man_done2 = 2'b10;
        @(negedge clk);
        man_done2 = 2'b00;
        chk("c2 core1 start drop", cst2, 2'b01);
        @(negedge clk);
        chk("c2 block2 reset", crst2, 2'b10);
        chk("c2 block2 id", cbid2[2*TCB-1:TCB], 2);
        chk("c2 block2 threads", ctc2[2*CW-1:CW], 2);
        man_done2 = 2'b11;  // core1 is in reset, its done must be ignored
        @(negedge clk);
        man_done2 = 2'b00;
        chk("c2 no early done", kdv2, 0);
        chk("c2 core1 busy", cst2, 2'b10);
        man_done2 = 2'b10;
        @(negedge clk);
        man_done2 = 2'b00;
        chk("c2 done_valid", kdv2, 1);
        chk("c2 done_id", kdid2, 3);
        chk("c2 busy", busy2, 0);
        @(negedge clk);
        chk("c2 single pulse", kdv2, 0);

        // fill the queue behind a stalled kernel
        auto_done = 0;
        push1(4, 1);
        wait_start(4'b0001, "fill blocker start");
        for (int i = 0; i < 4; i++) push1(4, i);
        chk("fill queue_count", qc1, 4);
        chk("fill launch_ready", lr1, 0);
        chk("fill busy", busy1, 1);
        lv1 = 1; ltc1 = 8'd4; lid1 = 2'd2;
        repeat (3) @(negedge clk);
        chk("fill 5th rejected", qc1, 4);
        lv1 = 0;
        exp_ids[0] = 1; exp_ids[1] = 0; exp_ids[2] = 1; exp_ids[3] = 2; exp_ids[4] = 3;
        auto_done = 1;
        idx = 0; cyc = 0;
        while (!(idx >= 5 && !busy1) && cyc < 300) begin
            @(negedge clk); cyc++;
            if (kdv1) begin
                if (idx < 5) chk($sformatf("fill order %0d", idx), kdid1, exp_ids[idx]);
                idx++;
            end
        end
        repeat (5) begin @(negedge clk); if (kdv1) idx++; end
        chk("fill done count", idx, 5);
        chk("fill idle", busy1, 0);

        // simultaneous completion of both blocks
        auto_done = 0;
        push1(8, 0);
        wait_start(4'b0011, "sim both started");
        man_done1 = 4'b0011;
        @(negedge clk);
        man_done1 = 4'b0000;
        chk("sim done_valid", kdv1, 1);
        chk("sim done_id", kdid1, 0);
        chk("sim busy", busy1, 0);
        @(negedge clk);
        chk("sim single pulse", kdv1, 0);

        // reset in the middle of a run
        push1(8, 1);
        wait_start(4'b0011, "mid-rst started");
        push1(4, 3);
        chk("mid-rst queued", qc1, 1);
        reset = 1'b0;
        #1;
        chk("mid-rst core_start", cst1, 0);
        chk("mid-rst core_reset", crst1, 0);
        chk("mid-rst queue_count", qc1, 0);
        chk("mid-rst launch_ready", lr1, 0);
        chk("mid-rst busy", busy1, 0);
        @(negedge clk);
        reset = 1'b1;
        spurious = 0;
        repeat (6) begin @(negedge clk); if (kdv1 || cst1 != 0) spurious++; end
        chk("mid-rst quiet after", spurious, 0);
        run_kernel(4, 2, 1, 4, 1, "post-rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
